// File: rtl/dds_wave_gen.sv
// DDS waveform core: phase accumulator, phase offset, sine ROM port and a
// 4-stage sample pipeline producing a 14-bit offset-binary stream.
module dds_wave_gen #(
   parameter int P_ACC_W  = 27,
   parameter int P_DATA_W = 14,
   parameter int P_ROM_AW = 8
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_run,
   input  logic                i_run_vld,
   input  logic [P_ACC_W-1:0]  i_fword,
   input  logic                i_fword_vld,
   input  logic [P_ROM_AW-1:0] i_pword,
   input  logic                i_pword_vld,
   input  logic [2:0]          i_mode,
   input  logic                i_mode_vld,
   input  logic [9:0]          i_duty,
   input  logic                i_duty_vld,
   output logic [P_ROM_AW-1:0] o_rom_addr,
   input  logic [P_DATA_W-1:0] i_rom_data,
   output logic [P_DATA_W-1:0] o_dds_data,
   output logic                o_dds_data_vld,
   output logic                o_sync
);

   typedef enum logic [2:0] {
      M_SINE   = 3'd0,
      M_SQUARE = 3'd1,
      M_TRI    = 3'd2,
      M_SAW_UP = 3'd3,
      M_SAW_DN = 3'd4,
      M_DC     = 3'd5
   } mode_e;

   localparam int                  LP_SHIFT = P_DATA_W - P_ROM_AW;
   localparam logic [P_DATA_W-1:0] LP_FULL  = '1;
   localparam logic [P_DATA_W-1:0] LP_MID   = {1'b1, {(P_DATA_W-1){1'b0}}};

   // latched control words
   logic                r_run;
   logic [P_ACC_W-1:0]  r_fword;
   logic [P_ROM_AW-1:0] r_pword;
   mode_e               r_mode;
   logic [9:0]          r_duty;
   logic [P_DATA_W-1:0] r_thresh;

   // pipeline state
   logic [P_ACC_W-1:0]  r_acc;
   logic                r_wrap;
   logic [P_DATA_W-1:0] r_p14_s1, r_p14_s2;
   logic                r_wrap_s1, r_wrap_s2;
   logic                r_run_s1, r_run_s2;

   logic [P_ACC_W:0]    w_acc_sum;
   logic [P_DATA_W-1:0] w_sample;

   assign w_acc_sum = {1'b0, r_acc} + {1'b0, r_fword};

   // r_acc/r_wrap pair with the current r_run as the stage-0 sample, so the
   // value held while stopped (0) becomes the first sample after a restart.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_run          <= 1'b1;
         r_fword        <= P_ACC_W'(64);
         r_pword        <= '0;
         r_mode         <= M_SINE;
         r_duty         <= 10'd1;
         r_thresh       <= P_DATA_W'(16);
         r_acc          <= '0;
         r_wrap         <= 1'b0;
         r_p14_s1       <= '0;
         r_p14_s2       <= '0;
         r_wrap_s1      <= 1'b0;
         r_wrap_s2      <= 1'b0;
         r_run_s1       <= 1'b0;
         r_run_s2       <= 1'b0;
         o_rom_addr     <= '0;
         o_dds_data     <= LP_MID;
         o_dds_data_vld <= 1'b0;
         o_sync         <= 1'b0;
      end else begin
         if (i_run_vld)   r_run   <= i_run;
         if (i_fword_vld) r_fword <= i_fword;
         if (i_pword_vld) r_pword <= i_pword;
         if (i_mode_vld)  r_mode  <= mode_e'(i_mode);
         if (i_duty_vld)  r_duty  <= i_duty;
         r_thresh <= P_DATA_W'((25'(r_duty) * 25'd16777) >> 10);

         if (r_run) begin
            r_acc  <= w_acc_sum[P_ACC_W-1:0];
            r_wrap <= w_acc_sum[P_ACC_W];
         end else begin
            r_acc  <= '0;
            r_wrap <= 1'b0;
         end

         r_p14_s1   <= r_acc[P_ACC_W-1 -: P_DATA_W] + {r_pword, {LP_SHIFT{1'b0}}};
         o_rom_addr <= r_acc[P_ACC_W-1 -: P_ROM_AW] + r_pword;
         r_wrap_s1  <= r_wrap;
         r_run_s1   <= r_run;

         r_p14_s2  <= r_p14_s1;
         r_wrap_s2 <= r_wrap_s1;
         r_run_s2  <= r_run_s1;

         o_dds_data     <= r_run_s2 ? w_sample : LP_MID;
         o_dds_data_vld <= r_run_s2;
         o_sync         <= r_wrap_s2 & r_run_s2;
      end
   end

   // NOTE: default first so every mode path assigns w_sample and no latch is inferred.
   always_comb begin
      w_sample = LP_MID;
      case (r_mode)
         M_SINE:   w_sample = i_rom_data;
         M_SQUARE: begin
            if (r_duty >= 10'd1000)      w_sample = LP_FULL;
            else if (r_p14_s2 < r_thresh) w_sample = LP_FULL;
            else                          w_sample = '0;
         end
         M_TRI:    w_sample = r_p14_s2[P_DATA_W-1] ? ~{r_p14_s2[P_DATA_W-2:0], 1'b0}
                                                   :  {r_p14_s2[P_DATA_W-2:0], 1'b0};
         M_SAW_UP: w_sample = r_p14_s2;
         M_SAW_DN: w_sample = ~r_p14_s2;
         M_DC:     w_sample = LP_FULL;
         default:  w_sample = LP_MID;
      endcase
   end

endmodule

// File: tb/tb_dds_wave_gen.sv
// Self-checking bench for dds_wave_gen: stage-0 records are queued as the
// accumulator advances and checked when they reach the output three edges later.
module tb_dds_wave_gen;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_run, i_run_vld;
   logic [26:0] i_fword;
   logic        i_fword_vld;
   logic [7:0]  i_pword;
   logic        i_pword_vld;
   logic [2:0]  i_mode;
   logic        i_mode_vld;
   logic [9:0]  i_duty;
   logic        i_duty_vld;
   logic [7:0]  o_rom_addr;
   logic [13:0] i_rom_data;
   logic [13:0] o_dds_data;
   logic        o_dds_data_vld;
   logic        o_sync;

   dds_wave_gen dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_run          (i_run),
      .i_run_vld      (i_run_vld),
      .i_fword        (i_fword),
      .i_fword_vld    (i_fword_vld),
      .i_pword        (i_pword),
      .i_pword_vld    (i_pword_vld),
      .i_mode         (i_mode),
      .i_mode_vld     (i_mode_vld),
      .i_duty         (i_duty),
      .i_duty_vld     (i_duty_vld),
      .o_rom_addr     (o_rom_addr),
      .i_rom_data     (i_rom_data),
      .o_dds_data     (o_dds_data),
      .o_dds_data_vld (o_dds_data_vld),
      .o_sync         (o_sync)
   );

   always #5 i_clk = ~i_clk;

   // ROM stand-in: distinct word per address, one cycle read latency
   function automatic logic [13:0] rom_f(input logic [7:0] a);
      return {a, ~a[5:0]};
   endfunction

   always @(posedge i_clk) i_rom_data <= rom_f(o_rom_addr);

   typedef struct {
      logic [26:0] acc;
      logic        wrap;
      logic        run;
      logic [7:0]  pword;
   } rec_t;

   rec_t q[$];

   // reference model of the latched controls and accumulator
   logic        m_run;
   logic [26:0] m_fword;
   logic [7:0]  m_pword;
   logic [2:0]  m_mode;
   logic [9:0]  m_duty, m_duty_d1;
   logic [26:0] m_acc;
   logic        m_wrap;

   int n_checks = 0;
   int n_errors = 0;
   int cnt_sync, cnt_zero, cnt_full;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [13:0] exp_sample(input rec_t r, input logic [2:0] mode,
                                              input logic [9:0] duty, input logic [9:0] duty_d1);
      logic [13:0] p14, thr;
      p14 = r.acc[26:13] + {r.pword, 6'b0};
      thr = 14'((25'(duty_d1) * 25'd16777) >> 10);
      case (mode)
         3'd0:    return rom_f(p14[13:6]);
         3'd1:    return (duty >= 10'd1000) ? 14'd16383 : ((p14 < thr) ? 14'd16383 : 14'd0);
         3'd2:    return p14[13] ? ~{p14[12:0], 1'b0} : {p14[12:0], 1'b0};
         3'd3:    return p14;
         3'd4:    return ~p14;
         3'd5:    return 14'd16383;
         default: return 14'd8192;
      endcase
   endfunction

   task automatic tick();
      rec_t        r, prev, inv, r0;
      logic [13:0] e_data;
      logic        e_vld, e_sync;
      logic [7:0]  e_addr;
      logic        c;
      @(posedge i_clk);
      if (i_rst) begin
         m_run = 1'b1; m_fword = 27'd64; m_pword = '0; m_mode = '0;
         m_duty = 10'd1; m_duty_d1 = 10'd1; m_acc = '0; m_wrap = 1'b0;
         inv = '{acc: '0, wrap: 1'b0, run: 1'b0, pword: '0};
         r0  = '{acc: '0, wrap: 1'b0, run: 1'b1, pword: '0};
         q.delete();
         q.push_back(inv); q.push_back(inv); q.push_back(r0);
         e_data = 14'd8192; e_vld = 1'b0; e_sync = 1'b0; e_addr = '0;
      end else begin
         r      = q.pop_front();
         prev   = q[$];
         e_addr = prev.acc[26:19] + prev.pword;
         e_vld  = r.run;
         e_sync = r.run & r.wrap;
         e_data = r.run ? exp_sample(r, m_mode, m_duty, m_duty_d1) : 14'd8192;
         // accumulator advances on the controls held before this edge
         if (m_run) {c, m_acc} = {1'b0, m_acc} + {1'b0, m_fword};
         else begin c = 1'b0; m_acc = '0; end
         m_wrap    = c;
         m_duty_d1 = m_duty;
         if (i_run_vld)   m_run   = i_run;
         if (i_fword_vld) m_fword = i_fword;
         if (i_pword_vld) m_pword = i_pword;
         if (i_mode_vld)  m_mode  = i_mode;
         if (i_duty_vld)  m_duty  = i_duty;
         q.push_back('{acc: m_acc, wrap: m_wrap, run: m_run, pword: m_pword});
      end
      #1;
      check("dds_data", 32'(o_dds_data), 32'(e_data));
      check("dds_vld",  32'(o_dds_data_vld), 32'(e_vld));
      check("sync",     32'(o_sync), 32'(e_sync));
      check("rom_addr", 32'(o_rom_addr), 32'(e_addr));
      if (o_sync) cnt_sync++;
      if (o_dds_data_vld && o_dds_data == 14'd0)     cnt_zero++;
      if (o_dds_data_vld && o_dds_data == 14'd16383) cnt_full++;
      i_run_vld = 1'b0; i_fword_vld = 1'b0; i_pword_vld = 1'b0;
      i_mode_vld = 1'b0; i_duty_vld = 1'b0; i_mode = 3'd0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic clr_counts();
      cnt_sync = 0; cnt_zero = 0; cnt_full = 0;
   endtask

   initial begin
      i_rst = 1'b1;
      i_run = 1'b0; i_run_vld = 1'b0;
      i_fword = '0; i_fword_vld = 1'b0;
      i_pword = '0; i_pword_vld = 1'b0;
      i_mode = '0;  i_mode_vld = 1'b0;
      i_duty = '0;  i_duty_vld = 1'b0;
      clr_counts();

      // 1: reset release, default sine at fword 64, ROM address crosses a step
      ticks(2);
      i_rst = 1'b0;
      ticks(8200);

      // 2: stop, then restart as saw-up at 2^20 with all strobes in one cycle
      i_run = 1'b0; i_run_vld = 1'b1;
      tick();
      ticks(6);
      i_run = 1'b1; i_run_vld = 1'b1;
      i_fword = 27'd1 << 20; i_fword_vld = 1'b1;
      i_mode = 3'd3; i_mode_vld = 1'b1;
      tick();
      ticks(10);
      clr_counts();
      ticks(256);
      check("saw_sync_count", cnt_sync, 2);
      check("saw_zero_count", cnt_zero, 2);

      // 3: square at 25 %, then the 100 % and 0 % edges
      i_mode = 3'd1; i_mode_vld = 1'b1;
      i_duty = 10'd250; i_duty_vld = 1'b1;
      tick();
      ticks(10);
      clr_counts();
      ticks(128);
      check("sq250_high", cnt_full, 32);
      check("sq250_low",  cnt_zero, 96);
      i_duty = 10'd1000; i_duty_vld = 1'b1;
      tick();
      ticks(5);
      clr_counts();
      ticks(64);
      check("sq1000_high", cnt_full, 64);
      i_duty = 10'd0; i_duty_vld = 1'b1;
      tick();
      ticks(5);
      clr_counts();
      ticks(64);
      check("sq0_low", cnt_zero, 64);

      // 4: triangle, then a quarter-period phase shift mid-run
      i_mode = 3'd2; i_mode_vld = 1'b1;
      tick();
      ticks(300);
      i_pword = 8'd64; i_pword_vld = 1'b1;
      tick();
      ticks(100);

      // 5: mode without strobe ignored; stop/restart with new fword; sine via strobe
      i_mode = 3'd0;
      tick();
      ticks(20);
      i_run = 1'b0; i_run_vld = 1'b1;
      tick();
      ticks(10);
      i_run = 1'b1; i_run_vld = 1'b1;
      i_fword = 27'd1 << 19; i_fword_vld = 1'b1;
      tick();
      ticks(50);
      i_mode = 3'd0; i_mode_vld = 1'b1;
      tick();
      ticks(50);
      i_fword = '0; i_fword_vld = 1'b1;
      tick();
      ticks(5);
      clr_counts();
      ticks(50);
      check("frozen_no_sync", cnt_sync, 0);

      // 6: one-cycle reset in mid-stream
      i_fword = 27'd1 << 20; i_fword_vld = 1'b1;
      i_mode = 3'd4; i_mode_vld = 1'b1;
      tick();
      ticks(20);
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      ticks(20);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
